// File: rtl/posit_pkg.sv
// Shared types for the posit result path: FIFO entry layout and the NaR constant.
package posit_pkg;

  localparam int POSIT_W_MAX     = 64;
  localparam int POSIT_TAG_W_MAX = 8;
  localparam int POSIT_SRC_W_MAX = 3;

  localparam logic [31:0] POSIT_NAR_32 = 32'h8000_0000;

  // Sized for the widest supported configuration; narrower builds zero-pad.
  typedef struct packed {
    logic [POSIT_W_MAX-1:0]     result;
    logic [POSIT_TAG_W_MAX-1:0] tag;
    logic [POSIT_SRC_W_MAX-1:0] src;
    logic                       nar;
  } result_entry_t;

endpackage

// File: rtl/posit_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, registered rotating priority pointer.
module posit_rr_arbiter #(
  parameter int N     = 3,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N-1:0]     req_i,
  input  logic             en_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic [IDX_W-1:0] rr_o
);

  logic [IDX_W-1:0] rr_q;
  logic             found;
  int               j;

  // Scan starts at rr_q and wraps, so the last winner gets lowest priority.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(rr_q) + k;
      if (j >= N) j = j - N;
      if (en_i && !found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IDX_W'(j);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)
      rr_q <= '0;
    else if (found)
      rr_q <= (idx_o == IDX_W'(N-1)) ? '0 : idx_o + 1'b1;
  end

  assign rr_o = rr_q;

endmodule

// File: rtl/posit_result_arbiter.sv
// Collects posit FPU unit results round-robin into a small FIFO for writeback.
// Optional perf counters enabled by defining POSIT_ARB_PERF_EN.
module posit_result_arbiter
  import posit_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NUM_SRC = 3,
  parameter int TAG_W   = 5,
  parameter int DEPTH   = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            flush_i,
  input  logic [NUM_SRC-1:0]              src_valid_i,
  output logic [NUM_SRC-1:0]              src_ready_o,
  input  logic [NUM_SRC-1:0][WIDTH-1:0]   src_result_i,
  input  logic [NUM_SRC-1:0][TAG_W-1:0]   src_tag_i,
  output logic                            out_valid_o,
  input  logic                            out_ready_i,
  output logic [WIDTH-1:0]                out_result_o,
  output logic [TAG_W-1:0]                out_tag_o,
  output logic [$clog2(NUM_SRC)-1:0]      out_src_o,
  output logic                            out_nar_o,
  output logic [31:0]                     perf_stall_o,
  output logic [31:0]                     perf_count_o
);

  localparam int SRC_W = $clog2(NUM_SRC);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [WIDTH-1:0] NAR = {1'b1, {(WIDTH-1){1'b0}}};

  logic [CNT_W-1:0] count_q;
  logic [PTR_W-1:0] wp_q, rp_q;
  logic             full, push, pop, arb_en;
  logic [SRC_W-1:0] gnt_idx, rr_unused;
  result_entry_t    mem [DEPTH];
  result_entry_t    wr_entry, head;

  // Fullness uses registered count only; a pop never frees a slot in the same cycle.
  assign full   = (count_q == CNT_W'(DEPTH));
  assign arb_en = !rst_i && !flush_i && !full;

  posit_rr_arbiter #(.N(NUM_SRC), .IDX_W(SRC_W)) u_arb (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req_i (src_valid_i),
    .en_i  (arb_en),
    .gnt_o (src_ready_o),
    .idx_o (gnt_idx),
    .rr_o  (rr_unused)
  );

  assign push = |src_ready_o;
  assign pop  = out_valid_o && out_ready_i;

  always_comb begin
    wr_entry        = '0;
    wr_entry.result = POSIT_W_MAX'(src_result_i[gnt_idx]);
    wr_entry.tag    = POSIT_TAG_W_MAX'(src_tag_i[gnt_idx]);
    wr_entry.src    = POSIT_SRC_W_MAX'(gnt_idx);
    wr_entry.nar    = (src_result_i[gnt_idx] == NAR);
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wp_q] <= wr_entry;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      count_q <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
    end else begin
      if (push) wp_q <= wp_q + 1'b1;
      if (pop)  rp_q <= rp_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head         = mem[rp_q];
  assign out_valid_o  = (count_q != '0);
  assign out_result_o = out_valid_o ? WIDTH'(head.result) : '0;
  assign out_tag_o    = out_valid_o ? TAG_W'(head.tag)    : '0;
  assign out_src_o    = out_valid_o ? SRC_W'(head.src)    : '0;
  assign out_nar_o    = out_valid_o && head.nar;

  // Pad bits of the shared entry type and the exported pointer are not consumed here.
  logic unused_bits;
  assign unused_bits = ^{head, rr_unused};

`ifdef POSIT_ARB_PERF_EN
  logic [31:0] stall_q, deliv_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_q <= '0;
      deliv_q <= '0;
    end else begin
      if (|src_valid_i && !push && stall_q != '1) stall_q <= stall_q + 1'b1;
      if (pop && deliv_q != '1)                   deliv_q <= deliv_q + 1'b1;
    end
  end

  assign perf_stall_o = stall_q;
  assign perf_count_o = deliv_q;
`else
  assign perf_stall_o = '0;
  assign perf_count_o = '0;
`endif

endmodule

// File: tb/tb_posit_result_arbiter.sv
// Directed bench for posit_result_arbiter: reset, round robin, backpressure, NaR, flush, perf.
module tb_posit_result_arbiter;
  import posit_pkg::*;

  localparam int WIDTH = 32, NUM_SRC = 3, TAG_W = 5, DEPTH = 4;

  logic                          clk = 1'b0;
  logic                          rst, flush;
  logic [NUM_SRC-1:0]            src_valid, src_ready;
  logic [NUM_SRC-1:0][WIDTH-1:0] src_result;
  logic [NUM_SRC-1:0][TAG_W-1:0] src_tag;
  logic                          out_valid, out_ready, out_nar;
  logic [WIDTH-1:0]              out_result;
  logic [TAG_W-1:0]              out_tag;
  logic [1:0]                    out_src;
  logic [31:0]                   perf_stall, perf_count;

  int vectors = 0, miscompares = 0;

  posit_result_arbiter #(.WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .src_valid_i(src_valid), .src_ready_o(src_ready),
    .src_result_i(src_result), .src_tag_i(src_tag),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_result_o(out_result), .out_tag_o(out_tag), .out_src_o(out_src), .out_nar_o(out_nar),
    .perf_stall_o(perf_stall), .perf_count_o(perf_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0; src_valid = 3'b111;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_result[i] = 32'h1000_0000 * (i + 1);
      src_tag[i]    = TAG_W'(i + 1);
    end
    for (int c = 0; c < 2; c++) begin
      step();
      vectors++;
      if (src_ready !== 3'b000) begin miscompares++; $display("FAIL rst_ready c%0d: got %b exp 000", c, src_ready); end
      vectors++;
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid c%0d: got %b exp 0", c, out_valid); end
    end
    rst = 1'b0; #1;
    vectors++;
    if (src_ready !== 3'b001) begin miscompares++; $display("FAIL rst_first_grant: got %b exp 001", src_ready); end
    vectors++;
    if (out_result !== '0 || out_tag !== '0 || out_src !== '0 || out_nar !== 1'b0) begin
      miscompares++; $display("FAIL rst_empty_data: got %h/%h/%h/%b exp zeros", out_result, out_tag, out_src, out_nar);
    end
    vectors++;
    if (perf_stall !== 0 || perf_count !== 0) begin
      miscompares++; $display("FAIL rst_perf: got %0d/%0d exp 0/0", perf_stall, perf_count);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_gnt;
    out_ready = 1'b1; #1;
    for (int k = 0; k < 6; k++) begin
      exp_gnt = 3'b001 << (k % 3);
      vectors++;
      if (src_ready !== exp_gnt) begin miscompares++; $display("FAIL rr_grant k%0d: got %b exp %b", k, src_ready, exp_gnt); end
      if (k > 0) begin
        vectors++;
        if (out_valid !== 1'b1 || out_src !== 2'((k - 1) % 3) || out_tag !== TAG_W'((k - 1) % 3 + 1)) begin
          miscompares++;
          $display("FAIL rr_out k%0d: got v%b src%0d tag%0d exp v1 src%0d tag%0d",
                   k, out_valid, out_src, out_tag, (k - 1) % 3, (k - 1) % 3 + 1);
        end
      end
      step();
    end
    src_valid = 3'b000; #1;
    vectors++;
    if (out_src !== 2'd2 || out_result !== 32'h3000_0000) begin
      miscompares++; $display("FAIL rr_last: got src%0d %h exp src2 30000000", out_src, out_result);
    end
    step();
  endtask

  task automatic test_backpressure();
    logic [2:0] exp_gnt;
    out_ready = 1'b0; src_valid = 3'b010; #1;
    for (int k = 0; k < 6; k++) begin
      exp_gnt = (k < 4) ? 3'b010 : 3'b000;
      vectors++;
      if (src_ready !== exp_gnt) begin miscompares++; $display("FAIL bp_fill k%0d: got %b exp %b", k, src_ready, exp_gnt); end
      step();
    end
    out_ready = 1'b1; #1;
    vectors++;
    if (src_ready !== 3'b000 || out_valid !== 1'b1) begin
      miscompares++; $display("FAIL bp_pop_no_push: got rdy %b v%b exp 000 v1", src_ready, out_valid);
    end
    step();
    out_ready = 1'b0; #1;
    vectors++;
    if (src_ready !== 3'b010) begin miscompares++; $display("FAIL bp_resume: got %b exp 010", src_ready); end
    step();
    vectors++;
    if (src_ready !== 3'b000 || out_src !== 2'd1 || out_tag !== 5'd2) begin
      miscompares++; $display("FAIL bp_refull: got rdy %b src%0d tag%0d exp 000 src1 tag2", src_ready, out_src, out_tag);
    end
    src_valid = 3'b000; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) step();
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_drain: got v%b exp 0", out_valid); end
  endtask

  task automatic test_nar();
    out_ready = 1'b0; src_valid = 3'b100;
    src_result[2] = POSIT_NAR_32; src_tag[2] = 5'd7; #1;
    vectors++;
    if (src_ready !== 3'b100) begin miscompares++; $display("FAIL nar_grant0: got %b exp 100", src_ready); end
    step();
    src_result[2] = 32'h0000_0000; src_tag[2] = 5'd9; #1;
    vectors++;
    if (src_ready !== 3'b100) begin miscompares++; $display("FAIL nar_grant1: got %b exp 100", src_ready); end
    step();
    src_valid = 3'b000; #1;
    vectors++;
    if (out_nar !== 1'b1 || out_tag !== 5'd7 || out_result !== 32'h8000_0000 || out_src !== 2'd2) begin
      miscompares++; $display("FAIL nar_head0: got nar%b tag%0d %h src%0d exp nar1 tag7 80000000 src2",
                              out_nar, out_tag, out_result, out_src);
    end
    out_ready = 1'b1; step();
    vectors++;
    if (out_nar !== 1'b0 || out_tag !== 5'd9 || out_result !== 32'h0 || out_valid !== 1'b1) begin
      miscompares++; $display("FAIL nar_head1: got nar%b tag%0d %h v%b exp nar0 tag9 0 v1",
                              out_nar, out_tag, out_result, out_valid);
    end
    step();
    vectors++;
    if (out_valid !== 1'b0 || out_tag !== '0 || out_nar !== 1'b0) begin
      miscompares++; $display("FAIL nar_empty: got v%b tag%0d nar%b exp 0/0/0", out_valid, out_tag, out_nar);
    end
    src_result[2] = 32'h3000_0000; src_tag[2] = 5'd3;
  endtask

  task automatic test_flush();
    out_ready = 1'b0; src_valid = 3'b001;
    for (int k = 0; k < 3; k++) step();
    flush = 1'b1; #1;
    vectors++;
    if (src_ready !== 3'b000 || out_valid !== 1'b1) begin
      miscompares++; $display("FAIL flush_cycle: got rdy %b v%b exp 000 v1", src_ready, out_valid);
    end
    step();
    flush = 1'b0; #1;
    vectors++;
    if (out_valid !== 1'b0 || src_ready !== 3'b001) begin
      miscompares++; $display("FAIL flush_after: got v%b rdy %b exp v0 001", out_valid, src_ready);
    end
    step();
    vectors++;
    if (out_valid !== 1'b1 || out_src !== 2'd0 || out_tag !== 5'd1) begin
      miscompares++; $display("FAIL flush_regrant: got v%b src%0d tag%0d exp v1 src0 tag1", out_valid, out_src, out_tag);
    end
    src_valid = 3'b000; out_ready = 1'b1; step();
  endtask

  task automatic test_perf();
    logic [31:0] exp_stall, exp_count;
    rst = 1'b1; step(); rst = 1'b0;
    out_ready = 1'b0; src_valid = 3'b111;
    for (int k = 0; k < 9; k++) step();
`ifdef POSIT_ARB_PERF_EN
    exp_stall = 32'd5; exp_count = 32'd4;
`else
    exp_stall = 32'd0; exp_count = 32'd0;
`endif
    vectors++;
    if (perf_stall !== exp_stall || src_ready !== 3'b000) begin
      miscompares++; $display("FAIL perf_stall: got %0d rdy %b exp %0d 000", perf_stall, src_ready, exp_stall);
    end
    src_valid = 3'b000; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) step();
    vectors++;
    if (perf_count !== exp_count || out_valid !== 1'b0) begin
      miscompares++; $display("FAIL perf_count: got %0d v%b exp %0d v0", perf_count, out_valid, exp_count);
    end
    vectors++;
    if (perf_stall !== exp_stall) begin
      miscompares++; $display("FAIL perf_stall_hold: got %0d exp %0d", perf_stall, exp_stall);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_backpressure();
    test_nar();
    test_flush();
    test_perf();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/posit_result_arbiter.md
# posit_result_arbiter

Result-collection stage directly downstream of the posit FPU execution units (sign-inject, add, multiply). Arbitrates round-robin among up to NUM_SRC unit outputs and buffers accepted results in a small FIFO. Presents one tagged result per cycle to the core writeback port over a valid/ready handshake, flagging NaR results on the way out.

## Interface
- WIDTH, 32, posit width in bits
- NUM_SRC, 3, number of execution-unit result sources (2..8)
- TAG_W, 5, instruction tag width (destination register / ROB id)
- DEPTH, 4, result FIFO entries (power of two, ≥2)
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- flush_i  in  1  synchronous pipeline flush; discards buffered results
- src_valid_i  in  NUM_SRC  per-source result valid
- src_ready_o  out  NUM_SRC  per-source grant/accept (one-hot or zero)
- src_result_i  in  NUM_SRC×WIDTH  per-source posit result
- src_tag_i  in  NUM_SRC×TAG_W  per-source tag
- out_valid_o  out  1  FIFO head valid
- out_ready_i  in  1  writeback accepts head
- out_result_o  out  WIDTH  head posit value
- out_tag_o  out  TAG_W  head tag
- out_src_o  out  $clog2(NUM_SRC)  index of producing unit
- out_nar_o  out  1  head result equals NaR (1 followed by WIDTH-1 zeros)
- perf_stall_o  out  32  stall counter (see Configuration)
- perf_count_o  out  32  delivered-result counter (see Configuration)

## Operation
- Transfer on a source i when src_valid_i[i] && src_ready_o[i]; on output when out_valid_o && out_ready_i.
- Grant: src_ready_o is zero when count == DEPTH or flush_i; otherwise one-hot to the first valid source at index ≥ rr_q, wrapping modulo NUM_SRC. rr_q updates to (granted index + 1) mod NUM_SRC on each grant; unchanged with no grant.
- Fullness is based on the registered count only: no same-cycle pop-makes-room bypass. A full FIFO plus a pop accepts nothing that cycle.
- Push writes {result, tag, src index, nar}. nar is computed at push: result == {1'b1, (WIDTH-1)'b0}.
- Pop advances the read pointer. Simultaneous push and pop with 0 < count < DEPTH leaves count unchanged.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- flush_i: next cycle count = 0 and pointers = 0. Any pop in the flush cycle is still acknowledged to writeback. rr_q is preserved.
- Sources must hold valid/result/tag stable until granted. The block does not check this.

## Timing
- Reset values: out_valid_o 0, src_ready_o 0 in the reset cycle, rr_q 0, count 0, pointers 0, perf counters 0. out_result_o, out_tag_o, out_src_o and out_nar_o read 0 while empty.
- Latency: a result accepted in cycle N appears on out_valid_o in cycle N+1, registered from FIFO state.
- src_ready_o is combinational from src_valid_i, rr_q, count and flush_i. It does not depend on out_ready_i.
- Output data are driven from the FIFO head register/array with no combinational path from inputs.
- Reset has priority over flush_i, and flush_i has priority over push.
- Throughput: 1 result/cycle while not full. With out_ready_i held high, sustained throughput equals the input rate.

## Configuration
- POSIT_ARB_PERF_EN defined:
  - perf_stall_o counts cycles where |src_valid_i and no grant occurs.
  - perf_count_o counts output transfers.
  - Both are 32-bit, saturate at 2^32-1, and clear on rst_i only (not on flush).
- Not defined: both outputs are tied to 0 and no counter registers are synthesised.

## Structure
- posit_pkg: add result_entry_t struct {result, tag, src, nar} parameterised by width constants, and POSIT_NAR_32 constant.
- Sub-module posit_rr_arbiter: NUM_SRC request vector, enable, rr pointer in/out → one-hot grant plus index. Combinational grant, registered pointer inside.
- FIFO storage is inline in the top module.

## Test plan
- Reset: assert rst_i 2 cycles with all sources valid → src_ready_o = 0 and out_valid_o = 0 during reset. The first grant after release goes to src 0.
- Round robin: all 3 sources valid continuously, out_ready_i = 1 → grant order 0,1,2,0,1,2. out_src_o follows the same sequence one cycle later.
- Full/backpressure: out_ready_i = 0 with src 1 valid for 6 cycles → 4 accepts, then src_ready_o = 0. Then out_ready_i = 1 for 1 cycle → pop with no push that cycle. Push resumes the next cycle.
- NaR: src 2 pushes 32'h8000_0000 then 32'h0000_0000 → out_nar_o = 1, then 0. Tags are preserved in order.
- Flush: 3 entries buffered, flush_i for 1 cycle with src 0 valid → src_ready_o = 0 that cycle and out_valid_o = 0 the next. A src 0 grant follows per the preserved rr_q.
- Perf (macro defined): 5 cycles all-valid with FIFO full → perf_stall_o = 5. After 4 pops → perf_count_o = 4. Without the macro, both outputs read 0.
